// File: rtl/bike_counter_updown_init.sv
// Bounded up/down loop counter for BIKE control FSMs: programmable step,
// wrap or saturate at the range bounds, range-checked load and boundary pulses.
module bike_counter_updown_init #(
    parameter int SIZE      = 5,
    parameter int INIT      = 1,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = 16,
    parameter int STEP      = 1,
    parameter int SATURATE  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [SIZE-1:0] load_val,
    output logic [SIZE-1:0] cnt_out,
    output logic            at_min,
    output logic            at_max,
    output logic            bound_hit,
    output logic            load_err
);

    localparam int W = SIZE + 1;

    if (MIN_VALUE < 0 || MIN_VALUE > INIT || INIT > MAX_VALUE ||
        MAX_VALUE >= (1 << SIZE) || STEP < 1 ||
        STEP > MAX_VALUE - MIN_VALUE + 1) begin : g_cfg_error
        $error("bike_counter_updown_init: illegal SIZE/INIT/MIN_VALUE/MAX_VALUE/STEP combination");
    end

    // One extra bit so MIN+STEP and cnt+STEP never truncate.
    localparam logic [W-1:0] MIN_W  = W'(MIN_VALUE);
    localparam logic [W-1:0] MAX_W  = W'(MAX_VALUE);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W-1:0] INIT_W = W'(INIT);

    logic [SIZE-1:0] cnt_reg, cnt_next;
    logic            bound_hit_reg, bound_hit_next;
    logic            load_err_reg, load_err_next;

    logic [W-1:0] cnt_ext, load_ext;
    logic         down_ok, up_ok, load_lo, load_hi;

    assign cnt_ext  = {1'b0, cnt_reg};
    assign load_ext = {1'b0, load_val};
    assign down_ok  = cnt_ext >= (MIN_W + STEP_W);
    assign up_ok    = (cnt_ext + STEP_W) <= MAX_W;
    assign load_lo  = load_ext < MIN_W;
    assign load_hi  = load_ext > MAX_W;

    always_comb begin
        cnt_next       = cnt_reg;
        bound_hit_next = 1'b0;
        load_err_next  = 1'b0;
        if (load) begin
            load_err_next = load_lo | load_hi;
            if (load_lo)
                cnt_next = MIN_W[SIZE-1:0];
            else if (load_hi)
                cnt_next = MAX_W[SIZE-1:0];
            else
                cnt_next = load_val;
        end else if (enable) begin
            if (up) begin
                if (up_ok) begin
                    cnt_next = cnt_reg + STEP_W[SIZE-1:0];
                end else begin
                    // Wrap lands exactly on the opposite bound; the remainder is dropped.
                    cnt_next       = (SATURATE != 0) ? MAX_W[SIZE-1:0] : MIN_W[SIZE-1:0];
                    bound_hit_next = 1'b1;
                end
            end else begin
                if (down_ok) begin
                    cnt_next = cnt_reg - STEP_W[SIZE-1:0];
                end else begin
                    cnt_next       = (SATURATE != 0) ? MIN_W[SIZE-1:0] : MAX_W[SIZE-1:0];
                    bound_hit_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= INIT_W[SIZE-1:0];
            bound_hit_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            bound_hit_reg <= bound_hit_next;
            load_err_reg  <= load_err_next;
        end
    end

    assign cnt_out   = cnt_reg;
    assign at_min    = (cnt_ext == MIN_W);
    assign at_max    = (cnt_ext == MAX_W);
    assign bound_hit = bound_hit_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_bike_counter_updown_init.sv
// Three counter configurations (default wrap-down, stepped wrap, saturating)
// driven by shared stimulus; a scoreboard queue holds per-cycle expectations.
module tb_bike_counter_updown_init;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;

    logic [4:0] cnt_o [3];
    logic       amin_o [3];
    logic       amax_o [3];
    logic       bh_o [3];
    logic       le_o [3];

    always #5 clk = ~clk;

    localparam int C_MIN  [3] = '{0, 2, 0};
    localparam int C_MAX  [3] = '{16, 10, 16};
    localparam int C_STEP [3] = '{1, 3, 2};
    localparam int C_INIT [3] = '{1, 2, 15};
    localparam int C_SAT  [3] = '{0, 0, 1};

    bike_counter_updown_init dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .cnt_out(cnt_o[0]), .at_min(amin_o[0]),
        .at_max(amax_o[0]), .bound_hit(bh_o[0]), .load_err(le_o[0])
    );

    bike_counter_updown_init #(
        .SIZE(5), .INIT(2), .MIN_VALUE(2), .MAX_VALUE(10), .STEP(3), .SATURATE(0)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .cnt_out(cnt_o[1]), .at_min(amin_o[1]),
        .at_max(amax_o[1]), .bound_hit(bh_o[1]), .load_err(le_o[1])
    );

    bike_counter_updown_init #(
        .SIZE(5), .INIT(15), .MIN_VALUE(0), .MAX_VALUE(16), .STEP(2), .SATURATE(1)
    ) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .cnt_out(cnt_o[2]), .at_min(amin_o[2]),
        .at_max(amax_o[2]), .bound_hit(bh_o[2]), .load_err(le_o[2])
    );

    typedef struct packed {
        logic [4:0] cnt;
        logic       amin;
        logic       amax;
        logic       bh;
        logic       le;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    exp3_t sb_q[$];
    int    m_cnt [3];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_txn = 0;

    // Reference: the counter as plain integer arithmetic on the range rules.
    task automatic model(input int k, input bit r, input bit e, input bit u,
                         input bit l, input int lv, output exp_t x);
        bit bh, le;
        bh = 1'b0;
        le = 1'b0;
        if (r) begin
            m_cnt[k] = C_INIT[k];
        end else if (l) begin
            le = (lv < C_MIN[k]) || (lv > C_MAX[k]);
            if (lv < C_MIN[k])      m_cnt[k] = C_MIN[k];
            else if (lv > C_MAX[k]) m_cnt[k] = C_MAX[k];
            else                    m_cnt[k] = lv;
        end else if (e) begin
            if (u) begin
                if (m_cnt[k] + C_STEP[k] > C_MAX[k]) begin
                    m_cnt[k] = (C_SAT[k] != 0) ? C_MAX[k] : C_MIN[k];
                    bh = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + C_STEP[k];
                end
            end else begin
                if (m_cnt[k] - C_STEP[k] < C_MIN[k]) begin
                    m_cnt[k] = (C_SAT[k] != 0) ? C_MIN[k] : C_MAX[k];
                    bh = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] - C_STEP[k];
                end
            end
        end
        x.cnt  = 5'(m_cnt[k]);
        x.amin = (m_cnt[k] == C_MIN[k]);
        x.amax = (m_cnt[k] == C_MAX[k]);
        x.bh   = bh;
        x.le   = le;
    endtask

    task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp3_t x;
        exp_t  xe;
        @(negedge clk);
        reset    = r;
        enable   = e;
        up       = u;
        load     = l;
        load_val = 5'(lv);
        for (int k = 0; k < 3; k++) begin
            model(k, r, e, u, l, lv, xe);
            x[k] = xe;
        end
        sb_q.push_back(x);
    endtask

    task automatic chk(input string name, input int k, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL txn=%0d dut%0d %s got=%0d want=%0d", n_txn, k, name, got, want);
        end
    endtask

    // Monitor: every clock edge presents new outputs; compare against the oldest expectation.
    always begin
        exp3_t x;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("cnt_out",   k, int'(cnt_o[k]),  int'(x[k].cnt));
                chk("at_min",    k, int'(amin_o[k]), int'(x[k].amin));
                chk("at_max",    k, int'(amax_o[k]), int'(x[k].amax));
                chk("bound_hit", k, int'(bh_o[k]),   int'(x[k].bh));
                chk("load_err",  k, int'(le_o[k]),   int'(x[k].le));
            end
            $display("txn %0d: cnt a=%0d b=%0d c=%0d bh=%b%b%b le=%b%b%b",
                     n_txn, cnt_o[0], cnt_o[1], cnt_o[2],
                     bh_o[0], bh_o[1], bh_o[2], le_o[0], le_o[1], le_o[2]);
            n_txn++;
        end
    end

    initial begin
        // Reset and default down-count through the wrap.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 9);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        // Upward stepping: wrap in dut_b, saturation in dut_c.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Range-checked loads, load beating enable, reset beating both.
        cyc(0, 0, 0, 1, 12);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 7);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 9);
        cyc(0, 1, 1, 1, 4);
        cyc(0, 1, 0, 1, 31);
        cyc(0, 0, 0, 1, 7);
        cyc(1, 1, 1, 1, 3);
        cyc(0, 0, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 31)));
        end
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bike_counter_updown_init.md
Name: bike_counter_updown_init

Overview:
- Parametrised successor of the decreasing counter with initial value.
- Adds up/down direction, programmable step, bounded range [MIN_VALUE, MAX_VALUE], wrap or saturate mode, synchronous load with range check, and boundary flags.
- Used as loop/index counter in BIKE control FSMs (decoder iterations, column/row indices).
- With MIN_VALUE=0, STEP=1, SATURATE=0 and up=0 it is cycle-equivalent to the existing down counter, apart from reset style.

Parameters:
- SIZE, 5, counter width in bits.
- INIT, 1, value loaded on reset.
- MIN_VALUE, 0, lower bound of the count range.
- MAX_VALUE, 16, upper bound of the count range.
- STEP, 1, increment/decrement amount per enabled cycle.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at bound.
- Legal configuration: MIN_VALUE <= INIT <= MAX_VALUE < 2^SIZE and 1 <= STEP <= MAX_VALUE-MIN_VALUE+1.
- Illegal configurations are rejected at elaboration with $error.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance the counter by STEP this cycle.
- up  in  1  direction: 1 = count up, 0 = count down; sampled only when enable=1.
- load  in  1  load load_val this cycle.
- load_val  in  SIZE  value to load.
- cnt_out  out  SIZE  current count (register output).
- at_min  out  1  cnt_out == MIN_VALUE (combinational from the register).
- at_max  out  1  cnt_out == MAX_VALUE (combinational from the register).
- bound_hit  out  1  registered one-cycle pulse: the previous enabled step crossed a bound (wrapped or saturated).
- load_err  out  1  registered one-cycle pulse: the previous load was out of range and was clamped.

Behaviour:
- Reset values: cnt_out=INIT, bound_hit=0, load_err=0. at_min and at_max follow INIT.
- Priority each cycle: reset > load > enable > hold.
- Load: cnt_out <= clamp(load_val, MIN_VALUE, MAX_VALUE) on the next edge.
  - load_err=1 on the next cycle iff load_val < MIN_VALUE or load_val > MAX_VALUE.
  - bound_hit=0 on a load cycle.
- Enable with up=0:
  - If cnt_out >= MIN_VALUE+STEP: cnt_out <= cnt_out-STEP, bound_hit <= 0.
  - Otherwise (underflow): SATURATE=0 gives cnt_out <= MAX_VALUE; SATURATE=1 gives cnt_out <= MIN_VALUE. In both cases bound_hit <= 1.
- Enable with up=1:
  - If cnt_out <= MAX_VALUE-STEP: cnt_out <= cnt_out+STEP, bound_hit <= 0.
  - Otherwise (overflow): SATURATE=0 gives cnt_out <= MIN_VALUE; SATURATE=1 gives cnt_out <= MAX_VALUE. In both cases bound_hit <= 1.
- Saturate mode, already at the bound and stepping outward: value is unchanged and bound_hit=1 every such cycle.
- Wrap targets the opposite bound exactly; the remainder is discarded (non-modular, as in the existing counter).
- Arithmetic: all comparisons and sums in SIZE+1 bits, so intermediate results never truncate.
- Hold cycle (enable=0, load=0): cnt_out unchanged, bound_hit=0, load_err=0.
- Latency: one cycle from enable/load to new cnt_out. at_min/at_max add no extra cycle.
- Simultaneous load and enable: the load wins and the step is dropped.
- Reset asserted mid-sequence: INIT is restored on the next edge, regardless of load/enable.
- up is ignored when enable=0.

Test Plan:
- Defaults (SIZE=5, INIT=1, MAX=16): reset, then enable=1, up=0 for 3 cycles -> cnt_out 1,0,16,15. bound_hit=1 only in the cycle after 0->16. at_min=1 while cnt_out=0.
- MIN=2, MAX=10, STEP=3, SATURATE=0, INIT=2: up=1 for 4 cycles -> 5,8,2(wrap, bound_hit=1),5. up=0 from 5 -> 2, then 10 (bound_hit=1).
- SATURATE=1, MIN=0, MAX=16, INIT=15, STEP=2, up=1 -> 16 (bound_hit=1, at_max=1), then held at 16 with bound_hit=1 each enabled cycle. Deassert enable -> bound_hit=0.
- MIN=2, MAX=10: load load_val=12 -> cnt_out=10, load_err=1 for one cycle. Load 1 -> 2, load_err=1. Load 7 -> 7, load_err=0.
- load=1, enable=1, load_val=4, from cnt_out=9 -> cnt_out=4 (step dropped), bound_hit=0.
- Mid-count reset (cnt_out=7) with load=1 and enable=1 in the same cycle -> cnt_out=INIT, bound_hit=0, load_err=0 on the next cycle.
